rate_lock_controller: RTL and testbench

Sequencing and configuration controller for the event-filter stage of the clock-recovery path. Owns the rate counter and measures the incoming half-period from raw edge events during acquisition. From that measurement it computes and programs the four half-rate limit thresholds for the filter, then supervises lock using the filter's accepted-event and violation flags. It sits between the edge detector (raw `event_i`) and the event filter, and reports lock status upstream.

---
 rtl/rate_lock_controller_if.sv | 50 +++++
 rtl/rate_lock_controller.sv | 202 ++++++++++++++++++++
 tb/tb_rate_lock_controller.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rate_lock_controller_if.sv
// ---------------------------------------------------------------------------
// rate_lock_controller_if
//   Groups the controller's edge-event, filter and status signals.
//
//   master : the rate_lock_controller itself (drives counter, limits, status)
//   slave  : the surrounding edge detector / event filter / supervisor
//
//   Signals (direction as seen by the controller):
//     enable_i                : level enable, low forces DISABLED
//     event_i                 : raw edge event pulse
//     filtered_event_i        : accepted event from the filter
//     over/under_violation_i  : filter violation flags
//     current_rate_counter_o  : rate counter to the filter
//     min_band_m1_o .. max_band_m1_o : programmed limits
//     half_period_o           : measured half-period H
//     locked_o, lock_lost_o   : lock status and lock-loss pulse
// ---------------------------------------------------------------------------
interface rate_lock_controller_if #(
    parameter int COUNTER_WIDTH = 16
);
    logic                     enable_i;
    logic                     event_i;
    logic                     filtered_event_i;
    logic                     over_violation_i;
    logic                     under_violation_i;
    logic [COUNTER_WIDTH-1:0] current_rate_counter_o;
    logic [COUNTER_WIDTH-1:0] min_band_m1_o;
    logic [COUNTER_WIDTH-1:0] min_violation_m1_o;
    logic [COUNTER_WIDTH-1:0] max_violation_m1_o;
    logic [COUNTER_WIDTH-1:0] max_band_m1_o;
    logic [COUNTER_WIDTH-1:0] half_period_o;
    logic                     locked_o;
    logic                     lock_lost_o;

    modport master (
        input  enable_i, event_i, filtered_event_i,
               over_violation_i, under_violation_i,
        output current_rate_counter_o, min_band_m1_o, min_violation_m1_o,
               max_violation_m1_o, max_band_m1_o, half_period_o,
               locked_o, lock_lost_o
    );

    modport slave (
        output enable_i, event_i, filtered_event_i,
               over_violation_i, under_violation_i,
        input  current_rate_counter_o, min_band_m1_o, min_violation_m1_o,
               max_violation_m1_o, max_band_m1_o, half_period_o,
               locked_o, lock_lost_o
    );
endinterface

// File: rtl/rate_lock_controller.sv
// ---------------------------------------------------------------------------
// rate_lock_controller
//   Measures the incoming half-period from raw edge events, programs the four
//   half-rate limit thresholds of the event filter and supervises lock using
//   the filter's accepted-event and violation flags.
//
//   Ports:
//     clk_i  : single clock, rising edge
//     rst_i  : synchronous active-high reset
//     bus    : rate_lock_controller_if.master (events, filter flags, limits,
//              rate counter, half-period, lock status)
//
//   Configuration macro:
//     CLKS_ALOT_AUTO_RELOCK_EN : defined -> lock loss returns to ARM and
//                                re-acquires automatically; undefined -> lock
//                                loss parks in FAULT until enable_i drops.
// ---------------------------------------------------------------------------
module rate_lock_controller #(
    parameter int COUNTER_WIDTH   = 16,
    parameter int ACQ_LOG2        = 2,
    parameter int TOL_SHIFT       = 3,
    parameter int VIOLATION_LIMIT = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    rate_lock_controller_if.master bus
);
    localparam int CW = COUNTER_WIDTH;
    localparam int SW = COUNTER_WIDTH + ACQ_LOG2;   // acquisition sum width
    localparam int AW = COUNTER_WIDTH + 2;          // signed limit arithmetic
    localparam int IW = ACQ_LOG2 + 1;               // interval count width
    localparam int VW = $clog2(VIOLATION_LIMIT + 1);
    localparam logic [CW-1:0]        CNT_MAX = {CW{1'b1}};
    localparam logic [IW-1:0]        ACQ_LAST = IW'((1 << ACQ_LOG2) - 1);
    localparam logic [VW-1:0]        VIOL_LAST = VW'(VIOLATION_LIMIT - 1);
    localparam logic signed [AW-1:0] ONE = AW'(1);

    typedef enum logic [2:0] {
        S_DISABLED,
        S_ARM,
        S_ACQUIRE,
        S_COMPUTE,
        S_LOCKED,
        S_FAULT
    } state_t;

    state_t        state;
    logic [CW-1:0] counter;
    logic [SW-1:0] sum;
    logic [IW-1:0] intervals;
    logic [VW-1:0] viol_cnt;
    logic [CW-1:0] min_band, min_viol, max_viol, max_band;
    logic [CW-1:0] half_period;
    logic          locked;
    logic          lock_lost;

    // Limit computation, only consumed during the COMPUTE cycle.
    logic [CW-1:0]        h_calc, t_calc;
    logic signed [AW-1:0] h_s, t_s;
    logic [CW-1:0]        min_band_calc, min_viol_calc, max_viol_calc, max_band_calc;
    logic [CW-1:0]        cnt_inc;
    logic                 is_viol;
    logic                 lock_break;

    function automatic logic [CW-1:0] clamp(input logic signed [AW-1:0] v);
        if (v < 0)
            return '0;
        else if (v > $signed({2'b00, CNT_MAX}))
            return CNT_MAX;
        else
            return v[CW-1:0];
    endfunction

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        h_calc = CW'(sum >> ACQ_LOG2);
        t_calc = h_calc >> TOL_SHIFT;
        if (t_calc == '0)
            t_calc = CW'(1);
        h_s = $signed({2'b00, h_calc});
        t_s = $signed({2'b00, t_calc});
        min_band_calc = clamp(h_s - (t_s <<< 1) - ONE);
        min_viol_calc = clamp(h_s - t_s - ONE);
        max_viol_calc = clamp(h_s + t_s - ONE);
        max_band_calc = clamp(h_s + (t_s <<< 1) - ONE);

        cnt_inc = (counter == CNT_MAX) ? counter : counter + CW'(1);
        is_viol = bus.over_violation_i | bus.under_violation_i;
        // Lock breaks on the VIOLATION_LIMIT-th consecutive violating event,
        // or when no accepted event arrives before the counter saturates.
        lock_break = bus.filtered_event_i ? (is_viol && viol_cnt == VIOL_LAST)
                                          : (counter == CNT_MAX);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_DISABLED;
            counter     <= '0;
            sum         <= '0;
            intervals   <= '0;
            viol_cnt    <= '0;
            min_band    <= '0;
            min_viol    <= '0;
            max_viol    <= CNT_MAX;
            max_band    <= CNT_MAX;
            half_period <= '0;
            locked      <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            lock_lost <= 1'b0;
            if (!bus.enable_i) begin
                // Disable wins over everything, including a coincident event.
                lock_lost <= (state == S_LOCKED);
                state     <= S_DISABLED;
                counter   <= '0;
                sum       <= '0;
                intervals <= '0;
                viol_cnt  <= '0;
                locked    <= 1'b0;
                min_band  <= '0;
                min_viol  <= '0;
                max_viol  <= CNT_MAX;
                max_band  <= CNT_MAX;
            end else begin
                case (state)
                    S_DISABLED: begin
                        state   <= S_ARM;
                        counter <= '0;
                    end
                    S_ARM: begin
                        if (bus.event_i) begin
                            // Arming event starts the first interval; it is not measured.
                            counter   <= '0;
                            sum       <= '0;
                            intervals <= '0;
                            state     <= S_ACQUIRE;
                        end else begin
                            counter <= cnt_inc;
                        end
                    end
                    S_ACQUIRE: begin
                        counter <= bus.event_i ? '0 : cnt_inc;
                        if (counter == CNT_MAX) begin
                            // Interval too long to measure: restart the average.
                            sum       <= '0;
                            intervals <= '0;
                        end else if (bus.event_i) begin
                            sum       <= sum + SW'(counter) + SW'(1);
                            intervals <= intervals + IW'(1);
                            if (intervals == ACQ_LAST)
                                state <= S_COMPUTE;
                        end
                    end
                    S_COMPUTE: begin
                        counter     <= cnt_inc;
                        half_period <= h_calc;
                        min_band    <= min_band_calc;
                        min_viol    <= min_viol_calc;
                        max_viol    <= max_viol_calc;
                        max_band    <= max_band_calc;
                        viol_cnt    <= '0;
                        locked      <= 1'b1;
                        state       <= S_LOCKED;
                    end
                    S_LOCKED: begin
                        counter <= bus.filtered_event_i ? '0 : cnt_inc;
                        if (lock_break) begin
                            locked    <= 1'b0;
                            lock_lost <= 1'b1;
                            viol_cnt  <= '0;
`ifdef CLKS_ALOT_AUTO_RELOCK_EN
                            state    <= S_ARM;
                            min_band <= '0;
                            min_viol <= '0;
                            max_viol <= CNT_MAX;
                            max_band <= CNT_MAX;
`else
                            state <= S_FAULT;
`endif
                        end else if (bus.filtered_event_i) begin
                            viol_cnt <= is_viol ? viol_cnt + VW'(1) : '0;
                        end
                    end
                    S_FAULT: begin
                        counter <= cnt_inc;
                    end
                    default: state <= S_DISABLED;
                endcase
            end
        end
    end

    assign bus.current_rate_counter_o = counter;
    assign bus.min_band_m1_o          = min_band;
    assign bus.min_violation_m1_o     = min_viol;
    assign bus.max_violation_m1_o     = max_viol;
    assign bus.max_band_m1_o          = max_band;
    assign bus.half_period_o          = half_period;
    assign bus.locked_o               = locked;
    assign bus.lock_lost_o            = lock_lost;
endmodule

// File: tb/tb_rate_lock_controller.sv
// ---------------------------------------------------------------------------
// tb_rate_lock_controller
//   Self-checking bench for rate_lock_controller. Expected limits come from
//   the measured intervals via plain integer arithmetic; lock supervision is
//   predicted from the run of consecutive violating events.
// ---------------------------------------------------------------------------
module tb_rate_lock_controller;
    localparam int VIOLATION_LIMIT = 3;
    localparam int CNT_MAX = 65535;

    logic clk;
    logic rst;
    rate_lock_controller_if #(.COUNTER_WIDTH(16)) bus();

    rate_lock_controller #(
        .COUNTER_WIDTH(16),
        .ACQ_LOG2(2),
        .TOL_SHIFT(3),
        .VIOLATION_LIMIT(VIOLATION_LIMIT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_h;
    int exp_lim[4];

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int clamp16(input int v);
        return (v < 0) ? 0 : ((v > CNT_MAX) ? CNT_MAX : v);
    endfunction

    // H is the mean interval; limits are H -/+ T and H -/+ 2T, minus one.
    task automatic set_expected(input int ivals[4]);
        int s = 0;
        int t;
        foreach (ivals[i]) s += ivals[i];
        exp_h = s / 4;
        t = exp_h / 8;
        if (t < 1) t = 1;
        exp_lim[0] = clamp16(exp_h - 2 * t - 1);
        exp_lim[1] = clamp16(exp_h - t - 1);
        exp_lim[2] = clamp16(exp_h + t - 1);
        exp_lim[3] = clamp16(exp_h + 2 * t - 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.event_i          = 1'b0;
        bus.filtered_event_i = 1'b0;
        repeat (n) step();
    endtask

    task automatic pulse_event();
        bus.event_i = 1'b1;
        step();
        bus.event_i = 1'b0;
    endtask

    task automatic gap_event(input int n);
        idle(n - 1);
        pulse_event();
    endtask

    task automatic check_limits(input int e0, input int e1, input int e2, input int e3);
        check("min_band", int'(bus.min_band_m1_o), e0);
        check("min_viol", int'(bus.min_violation_m1_o), e1);
        check("max_viol", int'(bus.max_violation_m1_o), e2);
        check("max_band", int'(bus.max_band_m1_o), e3);
    endtask

    task automatic check_reset_values();
        check("rst_counter", int'(bus.current_rate_counter_o), 0);
        check_limits(0, 0, CNT_MAX, CNT_MAX);
        check("rst_half", int'(bus.half_period_o), 0);
        check("rst_locked", int'(bus.locked_o), 0);
        check("rst_lost", int'(bus.lock_lost_o), 0);
    endtask

    // Starts in ARM: arming event, then four measured intervals.
    task automatic acquire(input int ivals[4]);
        set_expected(ivals);
        pulse_event();
        for (int i = 0; i < 3; i++) gap_event(ivals[i]);
        idle(ivals[3] - 1);
        bus.event_i = 1'b1;
        step();
        bus.event_i = 1'b0;
        check("lock_t1", int'(bus.locked_o), 0);
        step();
        check("lock_t2", int'(bus.locked_o), 1);
        check("half_period", int'(bus.half_period_o), exp_h);
        check_limits(exp_lim[0], exp_lim[1], exp_lim[2], exp_lim[3]);
        check("lock_counter", int'(bus.current_rate_counter_o), 1);
    endtask

    task automatic send_filtered(input bit over, input bit under, input int gap);
        idle(gap - 1);
        bus.filtered_event_i  = 1'b1;
        bus.over_violation_i  = over;
        bus.under_violation_i = under;
        step();
        bus.filtered_event_i  = 1'b0;
        bus.over_violation_i  = 1'b0;
        bus.under_violation_i = 1'b0;
        check("flt_counter_clear", int'(bus.current_rate_counter_o), 0);
    endtask

    task automatic random_violation_run(input int n_ev);
        int consec = 0;
        bit ov;
        bit un;
        for (int i = 0; i < n_ev; i++) begin
            ov = ($urandom_range(9, 0) < 4);
            un = !ov && ($urandom_range(9, 0) < 3);
            send_filtered(ov, un, int'($urandom_range(60, 5)));
            consec = (ov || un) ? consec + 1 : 0;
            if (consec == VIOLATION_LIMIT) begin
                check("rnd_lost", int'(bus.lock_lost_o), 1);
                check("rnd_unlocked", int'(bus.locked_o), 0);
                return;
            end
            check("rnd_hold", int'(bus.locked_o), 1);
            check("rnd_no_lost", int'(bus.lock_lost_o), 0);
        end
    endtask

    task automatic toggle_enable();
        bus.enable_i = 1'b0;
        step();
        check("dis_locked", int'(bus.locked_o), 0);
        check("dis_counter", int'(bus.current_rate_counter_o), 0);
        check_limits(0, 0, CNT_MAX, CNT_MAX);
        bus.enable_i = 1'b1;
        step();
    endtask

    // FAULT must ignore raw events and keep the last programmed limits.
    task automatic check_fault_hold(input int l0, input int l1, input int l2, input int l3);
        for (int i = 0; i < 6; i++) gap_event(40);
        idle(2);
        check("fault_no_relock", int'(bus.locked_o), 0);
        check_limits(l0, l1, l2, l3);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int found;
        int steps;
        int prev;
        int ivals[4];
        int base;

        rst                   = 1'b1;
        bus.enable_i          = 1'b0;
        bus.event_i           = 1'b0;
        bus.filtered_event_i  = 1'b0;
        bus.over_violation_i  = 1'b0;
        bus.under_violation_i = 1'b0;
        step();
        step();
        check_reset_values();
        rst = 1'b0;
        bus.enable_i = 1'b1;
        step();

        // Nominal lock at a 40-cycle interval: 29/34/44/49.
        acquire('{40, 40, 40, 40});
        check_limits(29, 34, 44, 49);

        // Clean event resets the violation run; the third in a row breaks lock.
        send_filtered(1, 0, 40);  check("v_hold1", int'(bus.locked_o), 1);
        send_filtered(1, 0, 40);  check("v_hold2", int'(bus.locked_o), 1);
        send_filtered(0, 0, 40);  check("v_hold3", int'(bus.locked_o), 1);
        send_filtered(0, 1, 40);  check("v_hold4", int'(bus.locked_o), 1);
        send_filtered(1, 0, 40);  check("v_hold5", int'(bus.locked_o), 1);
        check("v_no_lost", int'(bus.lock_lost_o), 0);
        send_filtered(1, 0, 40);
        check("v_lost", int'(bus.lock_lost_o), 1);
        check("v_unlocked", int'(bus.locked_o), 0);
        idle(1);
        check("v_lost_pulse", int'(bus.lock_lost_o), 0);
`ifdef CLKS_ALOT_AUTO_RELOCK_EN
        check_limits(0, 0, CNT_MAX, CNT_MAX);
        acquire('{40, 40, 40, 40});
`else
        check_fault_hold(29, 34, 44, 49);
`endif
        toggle_enable();

        // Randomised acquisition intervals and violation patterns.
        for (int r = 0; r < 3; r++) begin
            base = int'($urandom_range(280, 20));
            foreach (ivals[i]) ivals[i] = base + int'($urandom_range(16, 0)) - 8;
            acquire(ivals);
            random_violation_run(12);
            toggle_enable();
        end

        // Shortest half-period: min_band clamps from -1 to 0.
        acquire('{2, 2, 2, 2});
        check_limits(0, 0, 2, 3);
        toggle_enable();

        // Reset after two intervals; a fresh arming event plus four intervals is needed.
        pulse_event();
        gap_event(40);
        gap_event(40);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_values();
        step();
        set_expected('{40, 40, 40, 40});
        pulse_event();
        for (int i = 0; i < 3; i++) gap_event(40);
        idle(2);
        check("rst_no_early_lock", int'(bus.locked_o), 0);
        idle(37);
        pulse_event();
        check("rst_relock_t1", int'(bus.locked_o), 0);
        step();
        check("rst_relock_t2", int'(bus.locked_o), 1);
        check("rst_relock_half", int'(bus.half_period_o), exp_h);

        // Events stop while locked: counter saturates and lock is lost.
        found = 0;
        steps = 0;
        prev  = 0;
        for (int s = 1; s <= 70000; s++) begin
            prev = int'(bus.current_rate_counter_o);
            step();
            if (bus.lock_lost_o === 1'b1) begin
                found = 1;
                steps = s;
                break;
            end
        end
        check("sat_found", found, 1);
        check("sat_cycles", steps, 65535);
        check("sat_counter", prev, CNT_MAX);
        check("sat_unlocked", int'(bus.locked_o), 0);
`ifdef CLKS_ALOT_AUTO_RELOCK_EN
        acquire('{40, 40, 40, 40});
`else
        check_fault_hold(29, 34, 44, 49);
        toggle_enable();
        acquire('{40, 40, 40, 40});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
